// File: rtl/modn_seq_monitor.sv
// Purpose: receive-side checker for a mod-N up/down count bus. It classifies samples, locks onto the sequence and tallies errors.
// Latency: every output is registered, so a pulse appears in the cycle after the edge that sampled the causing count.
// Backpressure: none. Every in_valid sample is accepted, and an idle cycle leaves all state unchanged.
module modn_seq_monitor #(
  parameter int N        = 10,
  parameter int MSB      = 4,
  parameter int LOCK_LEN = 3,
  parameter int ERRW     = 8
) (
  input  logic            clk,
  input  logic            arst,
  input  logic            in_valid,
  input  logic [MSB-1:0]  count_in,
  input  logic            clr_err,
  output logic            locked,
  output logic            dir,
  output logic            wrap,
  output logic            rev,
  output logic            err,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [MSB-1:0]  TOP  = MSB'(N - 1);
  localparam logic [MSB:0]    NW   = (MSB + 1)'(N);
  localparam logic [ERRW-1:0] CMAX = '1;
  localparam logic [3:0]      LLEN = 4'(LOCK_LEN);

  typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;

  state_t         state;
  logic [MSB-1:0] prev;
  logic [3:0]     run;

  logic [MSB-1:0] nu, nd;
  logic           oor, stall, is_up, is_dn, step, jump, wstep, err_evt;
  logic [3:0]     run_nxt;

  // Classify the current sample against the last accepted value. UP wins the N==2 tie.
  always_comb begin
    nu      = (prev == TOP) ? '0 : prev + 1'b1;
    nd      = (prev == '0) ? TOP : prev - 1'b1;
    oor     = ({1'b0, count_in} >= NW);
    stall   = !oor && (count_in == prev);
    is_up   = !oor && !stall && (count_in == nu);
    is_dn   = !oor && !stall && !is_up && (count_in == nd);
    step    = is_up || is_dn;
    jump    = !oor && !stall && !step;
    wstep   = (is_up && prev == TOP) || (is_dn && prev == '0);
    // A fresh acquisition (run==0) or a change of direction restarts the run at 1.
    run_nxt = (run == 4'd0 || is_up != dir) ? 4'd1 : run + 4'd1;
    err_evt = in_valid && (oor || (state == LOCK && jump));
  end

  // Sequence-tracking FSM with registered flags and single-cycle pulses.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state  <= IDLE;
      prev   <= '0;
      run    <= '0;
      locked <= 1'b0;
      dir    <= 1'b1;
      wrap   <= 1'b0;
      rev    <= 1'b0;
      err    <= 1'b0;
    end else begin
      wrap <= 1'b0;
      rev  <= 1'b0;
      err  <= err_evt;
      if (in_valid) begin
        case (state)
          IDLE: begin
            if (!oor) begin
              prev  <= count_in;
              run   <= '0;
              state <= ACQ;
            end
          end
          ACQ: begin
            if (oor) begin
              state <= IDLE;
            end else if (step) begin
              prev <= count_in;
              dir  <= is_up;
              run  <= run_nxt;
              if (run_nxt == LLEN) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else if (jump) begin
              prev <= count_in;
              run  <= '0;
            end
          end
          LOCK: begin
            if (oor) begin
              locked <= 1'b0;
              state  <= IDLE;
            end else if (step) begin
              prev <= count_in;
              wrap <= wstep;
              if (is_up != dir) begin
                dir <= is_up;
                rev <= 1'b1;
              end
            end else if (jump) begin
              prev   <= count_in;
              run    <= '0;
              locked <= 1'b0;
              state  <= ACQ;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Saturating error tally. A clear takes priority over an increment in the same cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_cnt <= '0;
    end else if (clr_err) begin
      err_cnt <= '0;
    end else if (err_evt && err_cnt != CMAX) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_modn_seq_monitor.sv
// Directed bench for modn_seq_monitor. It uses N=10 and LOCK_LEN=3, with err_cnt widths of 8 and 2.
// The driver queues hand-computed expected outputs, and the monitor checks them on the falling edge.
// It covers lock, wrap, reversal, jump and out-of-range errors, clear priority, saturation and async reset.
module tb_modn_seq_monitor;

  typedef struct packed {
    logic       l, d, w, r, e;
    logic [7:0] c;
    logic [1:0] c2;
  } obs_t;

  typedef struct {
    int   due;
    int   id;
    obs_t exp;
  } entry_t;

  logic       clk = 1'b0;
  logic       arst;
  logic       in_valid;
  logic [3:0] count_in;
  logic       clr_err;
  logic       locked, dir, wrap, rev, err;
  logic [7:0] err_cnt;
  logic       locked2, dir2, wrap2, rev2, err2;
  logic [1:0] err_cnt2;

  int     cyc    = 0;
  int     tests  = 0;
  int     failed = 0;
  int     vec_id = 0;
  entry_t sb[$];

  modn_seq_monitor #(.N(10), .MSB(4), .LOCK_LEN(3), .ERRW(8)) u_dut (
    .clk(clk), .arst(arst), .in_valid(in_valid), .count_in(count_in), .clr_err(clr_err),
    .locked(locked), .dir(dir), .wrap(wrap), .rev(rev), .err(err), .err_cnt(err_cnt)
  );

  modn_seq_monitor #(.N(10), .MSB(4), .LOCK_LEN(3), .ERRW(2)) u_dut2 (
    .clk(clk), .arst(arst), .in_valid(in_valid), .count_in(count_in), .clr_err(clr_err),
    .locked(locked2), .dir(dir2), .wrap(wrap2), .rev(rev2), .err(err2), .err_cnt(err_cnt2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic obs_t sample_dut();
    obs_t o;
    o = '{l: locked, d: dir, w: wrap, r: rev, e: err, c: err_cnt, c2: err_cnt2};
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got l=%0b d=%0b w=%0b r=%0b e=%0b cnt=%0d cnt2=%0d, want l=%0b d=%0b w=%0b r=%0b e=%0b cnt=%0d cnt2=%0d",
               name, act.l, act.d, act.w, act.r, act.e, act.c, act.c2,
               exp.l, exp.d, exp.w, exp.r, exp.e, exp.c, exp.c2);
    end
  endtask

  // Monitor: pop every expectation that has come due and compare it with the registered outputs.
  always @(negedge clk) begin
    entry_t ent;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      ent = sb.pop_front();
      check($sformatf("vec%0d", ent.id), sample_dut(), ent.exp);
    end
  end

  // Drive one cycle of stimulus and queue the outputs expected after the next rising edge.
  task automatic step(input logic v, input logic [3:0] val, input logic clr,
                      input logic l, input logic d, input logic w, input logic r,
                      input logic e, input logic [7:0] c, input logic [1:0] c2);
    entry_t ent;
    @(posedge clk);
    #1;
    in_valid = v;
    count_in = val;
    clr_err  = clr;
    vec_id++;
    ent.due = cyc + 1;
    ent.id  = vec_id;
    ent.exp = '{l: l, d: d, w: w, r: r, e: e, c: c, c2: c2};
    sb.push_back(ent);
  endtask

  initial begin
    obs_t rst_exp;
    rst_exp  = '{l: 1'b0, d: 1'b1, w: 1'b0, r: 1'b0, e: 1'b0, c: 8'd0, c2: 2'd0};
    arst     = 1'b0;
    in_valid = 1'b0;
    count_in = 4'd0;
    clr_err  = 1'b0;
    #1 arst = 1'b1;
    #3 check("reset_values", sample_dut(), rst_exp);
    repeat (2) @(posedge clk);
    @(negedge clk) arst = 1'b0;

    // Lock on an up-count from 0.
    step(1, 0, 0,  0,1,0,0,0, 0,0);
    step(1, 1, 0,  0,1,0,0,0, 0,0);
    step(1, 2, 0,  0,1,0,0,0, 0,0);
    step(1, 3, 0,  1,1,0,0,0, 0,0);
    step(1, 4, 0,  1,1,0,0,0, 0,0);
    // Locked up-count through the 9->0 wrap.
    step(1, 5, 0,  1,1,0,0,0, 0,0);
    step(1, 6, 0,  1,1,0,0,0, 0,0);
    step(1, 7, 0,  1,1,0,0,0, 0,0);
    step(1, 8, 0,  1,1,0,0,0, 0,0);
    step(1, 9, 0,  1,1,0,0,0, 0,0);
    step(1, 0, 0,  1,1,1,0,0, 0,0);
    step(1, 1, 0,  1,1,0,0,0, 0,0);
    // Reverse at 5, stall, then a downward wrap 0->9.
    step(1, 2, 0,  1,1,0,0,0, 0,0);
    step(1, 3, 0,  1,1,0,0,0, 0,0);
    step(1, 4, 0,  1,1,0,0,0, 0,0);
    step(1, 5, 0,  1,1,0,0,0, 0,0);
    step(1, 4, 0,  1,0,0,1,0, 0,0);
    step(1, 3, 0,  1,0,0,0,0, 0,0);
    step(1, 3, 0,  1,0,0,0,0, 0,0);
    step(1, 2, 0,  1,0,0,0,0, 0,0);
    step(1, 1, 0,  1,0,0,0,0, 0,0);
    step(1, 0, 0,  1,0,0,0,0, 0,0);
    step(1, 9, 0,  1,0,1,0,0, 0,0);
    step(1, 8, 0,  1,0,0,0,0, 0,0);
    // A jump while locked is an error. Relock across 9->0 without a wrap pulse.
    step(1, 7, 0,  1,0,0,0,0, 0,0);
    step(1, 6, 0,  1,0,0,0,0, 0,0);
    step(1, 5, 0,  1,0,0,0,0, 0,0);
    step(1, 4, 0,  1,0,0,0,0, 0,0);
    step(1, 7, 0,  0,0,0,0,1, 1,1);
    step(1, 8, 0,  0,1,0,0,0, 1,1);
    step(1, 9, 0,  0,1,0,0,0, 1,1);
    step(1, 0, 0,  1,1,0,0,0, 1,1);
    step(1, 1, 0,  1,1,0,0,0, 1,1);
    // Out-of-range samples, clear priority and saturation of the 2-bit tally.
    step(1, 12, 0, 0,1,0,0,1, 2,2);
    step(1, 13, 1, 0,1,0,0,1, 0,0);
    step(1, 14, 0, 0,1,0,0,1, 1,1);
    step(0, 0, 1,  0,1,0,0,0, 0,0);
    step(1, 15, 0, 0,1,0,0,1, 1,1);
    step(1, 10, 0, 0,1,0,0,1, 2,2);
    step(1, 11, 0, 0,1,0,0,1, 3,3);
    step(1, 12, 0, 0,1,0,0,1, 4,3);
    step(1, 13, 0, 0,1,0,0,1, 5,3);
    // Relock at 6, then an idle gap and a stall.
    step(1, 3, 0,  0,1,0,0,0, 5,3);
    step(1, 4, 0,  0,1,0,0,0, 5,3);
    step(1, 5, 0,  0,1,0,0,0, 5,3);
    step(1, 6, 0,  1,1,0,0,0, 5,3);
    step(0, 9, 0,  1,1,0,0,0, 5,3);
    step(1, 6, 0,  1,1,0,0,0, 5,3);
    step(0, 0, 0,  1,1,0,0,0, 5,3);
    @(posedge clk);
    @(negedge clk);
    #1 arst = 1'b1;
    #1 check("async_reset", sample_dut(), rst_exp);
    repeat (2) @(posedge clk);
    #1 check("reset_held", sample_dut(), rst_exp);
    @(negedge clk) arst = 1'b0;
    // After reset, acquire a down-count and wrap 0->9.
    step(1, 5, 0,  0,1,0,0,0, 0,0);
    step(1, 4, 0,  0,0,0,0,0, 0,0);
    step(1, 3, 0,  0,0,0,0,0, 0,0);
    step(1, 2, 0,  1,0,0,0,0, 0,0);
    step(1, 1, 0,  1,0,0,0,0, 0,0);
    step(1, 0, 0,  1,0,0,0,0, 0,0);
    step(1, 9, 0,  1,0,1,0,0, 0,0);
    // Locked jump, then a silent jump in ACQ and a reversal during acquisition.
    step(1, 5, 0,  0,0,0,0,1, 1,1);
    step(1, 2, 0,  0,0,0,0,0, 1,1);
    step(1, 3, 0,  0,1,0,0,0, 1,1);
    step(1, 4, 0,  0,1,0,0,0, 1,1);
    step(1, 3, 0,  0,0,0,0,0, 1,1);
    step(1, 2, 0,  0,0,0,0,0, 1,1);
    step(1, 1, 0,  1,0,0,0,0, 1,1);
    step(1, 11, 0, 0,0,0,0,1, 2,2);
    step(0, 0, 0,  0,0,0,0,0, 2,2);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      tests++;
      failed++;
      $display("FAIL drain: %0d expectations still queued, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
